// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the two-way demultiplexing router and its per-port
// buffers.
//
// Contents:
//   DEFAULT_WIDTH  default data width of every router port (16)
//   DEFAULT_DEPTH  default entry count of each per-port buffer (2)
//   CNT_WIDTH      width of the optional accepted-word counters (16)
//   PORT0 / PORT1  values of in_sel that select output port 0 / port 1
//   cnt_t          counter word type
//   port_e         readable names for the two destination ports
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 2;
    localparam int CNT_WIDTH     = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic {
        SEL_PORT0 = 1'b0,
        SEL_PORT1 = 1'b1
    } port_e;

    // Number of bits needed to index DEPTH entries; never less than one so
    // that a pointer always has a legal width.
    function automatic int ptr_bits(input int depth);
        int bits;
        bits = $clog2(depth);
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// ----------------------------------------------------------------------------
// demux_fifo
// Small synchronous FIFO used as the buffer behind one router output port.
// The head word is read combinationally from the storage array, so a word
// written on an edge is visible on head_data right after that edge.
//
// Parameters:
//   WIDTH  data width
//   DEPTH  number of entries, power of two and at least 2
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears pointers and occupancy
//   push       write push_data this cycle (ignored while full)
//   push_data  word to write
//   full       buffer holds DEPTH words
//   pop        remove the head word this cycle (ignored while empty)
//   empty      buffer holds no words
//   head_data  oldest word in the buffer
// ----------------------------------------------------------------------------
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic             push_ok;
    logic             pop_ok;

    // A push is taken only when there is room, even if the same cycle also
    // pops; this keeps the accept decision independent of downstream ready.
    assign full    = (occupancy == OCC_W'(DEPTH));
    assign empty   = (occupancy == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_data = mem[rd_ptr];

    // Storage is deliberately not reset: stale contents are unreachable once
    // the pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule : demux_fifo

// File: rtl/demux_router.sv
// ----------------------------------------------------------------------------
// demux_router
// Routes a single valid/ready input stream to one of two buffered output
// ports chosen per word by in_sel. Each port has its own demux_fifo, so
// backpressure on one port never stalls words headed for the other.
//
// Optional feature (macro DEMUX_COUNT_EN):
//   When defined, adds cnt0/cnt1, free-running 16-bit counts of words
//   accepted for each port, wrapping from 16'hFFFF to 16'h0000.
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     asynchronous active-low reset
//   in_valid/in_ready         upstream handshake
//   in_sel                    destination port of the current word
//   in_data                   upstream word
//   out0_valid/out0_ready     port 0 handshake
//   out0_data                 port 0 head word
//   out1_valid/out1_ready     port 1 handshake
//   out1_data                 port 1 head word
//   cnt0/cnt1                 accepted-word counters (DEMUX_COUNT_EN only)
// ----------------------------------------------------------------------------
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    // Ready looks only at the selected buffer's fullness, never at the
    // downstream ready inputs, so there is no combinational ready path.
    assign in_ready = (in_sel == PORT1) ? !full1 : !full0;

    assign push0 = in_valid && in_ready && (in_sel == PORT0);
    assign push1 = in_valid && in_ready && (in_sel == PORT1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .pop       (out0_ready),
        .empty     (empty0),
        .head_data (out0_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .pop       (out1_ready),
        .empty     (empty1),
        .head_data (out1_data)
    );

`ifdef DEMUX_COUNT_EN
    // Counters track accepted words only; a refused word is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) begin
                cnt0 <= cnt0 + cnt_t'(1);
            end
            if (push1) begin
                cnt1 <= cnt1 + cnt_t'(1);
            end
        end
    end
`endif

endmodule : demux_router

// File: tb/tb_demux_router.sv
// ----------------------------------------------------------------------------
// tb_demux_router
// Self-checking bench for demux_router. Words the bench expects the router to
// accept are queued per port; a monitor on the falling edge compares each
// port's valid and head word against its queue and retires entries on
// handshakes. Counter checks are compiled in when DEMUX_COUNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_demux_router;
    import demux_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_COUNT_EN
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
    logic [15:0]      cnt0_model;
    logic [15:0]      cnt1_model;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];

    demux_router #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Falling-edge monitor: valid must match queue occupancy, the head word
    // must match the queue front, and a handshake retires the front entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_output("out0_valid", 32'(out0_valid), 32'(exp_q0.size() != 0));
            if (out0_valid && exp_q0.size() != 0) begin
                check_output("out0_data", 32'(out0_data), 32'(exp_q0[0]));
                if (out0_ready) begin
                    void'(exp_q0.pop_front());
                end
            end
            check_output("out1_valid", 32'(out1_valid), 32'(exp_q1.size() != 0));
            if (out1_valid && exp_q1.size() != 0) begin
                check_output("out1_data", 32'(out1_data), 32'(exp_q1[0]));
                if (out1_ready) begin
                    void'(exp_q1.pop_front());
                end
            end
        end
    end

    // Drives one word for one cycle; 'accept' is the hand-derived expectation
    // of in_ready. Called just after a rising edge, returns just after the next.
    task automatic apply_stimulus(input logic sel, input logic [WIDTH-1:0] data,
                                  input logic accept);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(negedge clk);
        check_output("in_ready", 32'(in_ready), 32'(accept));
        @(posedge clk);
        if (accept) begin
            if (sel) begin
                exp_q1.push_back(data);
`ifdef DEMUX_COUNT_EN
                cnt1_model++;
`endif
            end else begin
                exp_q0.push_back(data);
`ifdef DEMUX_COUNT_EN
                cnt0_model++;
`endif
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        exp_q0.delete();
        exp_q1.delete();
`ifdef DEMUX_COUNT_EN
        cnt0_model = '0;
        cnt1_model = '0;
`endif
    endtask

    task automatic check_counts(input string tag);
`ifdef DEMUX_COUNT_EN
        check_output({tag, "_cnt0"}, 32'(cnt0), 32'(cnt0_model));
        check_output({tag, "_cnt1"}, 32'(cnt1), 32'(cnt1_model));
`else
        if (tag.len() == 0) begin
            $display("[TB] counters not built");
        end
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        flush_model();

        // Reset held with a word offered: nothing may be captured.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_out0_valid", 32'(out0_valid), 32'd0);
        check_output("reset_out1_valid", 32'(out1_valid), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_COUNT_EN
        check_output("reset_cnt0", 32'(cnt0), 32'd0);
        check_output("reset_cnt1", 32'(cnt1), 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);

        // Routing to both ports with downstream ready.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        apply_stimulus(1'b1, 16'hFFFE, 1'b1);
        idle(3);
        check_counts("routing");

        // Port 0 stalled: fills after two words, third refused, port 1 still flows.
        out0_ready = 1'b0;
        apply_stimulus(1'b0, 16'h0001, 1'b1);
        apply_stimulus(1'b0, 16'h0002, 1'b1);
        apply_stimulus(1'b0, 16'h0003, 1'b0);
        apply_stimulus(1'b1, 16'h1234, 1'b1);
        out0_ready = 1'b1;
        idle(4);

        // Push and pop together on a one-word buffer keeps occupancy at one,
        // so exactly one more word fits afterwards.
        out0_ready = 1'b0;
        apply_stimulus(1'b0, 16'h5555, 1'b1);
        out0_ready = 1'b1;
        apply_stimulus(1'b0, 16'hAAAA, 1'b1);
        out0_ready = 1'b0;
        apply_stimulus(1'b0, 16'hBBBB, 1'b1);
        apply_stimulus(1'b0, 16'hCCCC, 1'b0);
        // Full buffer refuses a push even while it pops.
        out0_ready = 1'b1;
        apply_stimulus(1'b0, 16'hDDDD, 1'b0);
        idle(4);
        check_counts("pushpop");

        // Reset mid-stream with both buffers full.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        apply_stimulus(1'b0, 16'h1111, 1'b1);
        apply_stimulus(1'b0, 16'h2222, 1'b1);
        apply_stimulus(1'b1, 16'h3333, 1'b1);
        apply_stimulus(1'b1, 16'h4444, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("midreset_out0_valid", 32'(out0_valid), 32'd0);
        check_output("midreset_out1_valid", 32'(out1_valid), 32'd0);
        check_output("midreset_in_ready", 32'(in_ready), 32'd1);
        flush_model();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        apply_stimulus(1'b1, 16'h5A5A, 1'b1);
        idle(2);
        check_counts("postreset");

`ifdef DEMUX_COUNT_EN
        // Counter wrap: 65536 words to port 1 after a fresh reset.
        rst_n = 1'b0;
        #1;
        flush_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 65536; i++) begin
            apply_stimulus(1'b1, 16'(i), 1'b1);
        end
        idle(2);
        check_output("wrap_cnt1", 32'(cnt1), 32'h0000);
        check_output("wrap_cnt0", 32'(cnt0), 32'h0000);
`endif

        // Everything the bench expected must have come out.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
                idle(1);
            end
        end
        check_output("drain_left", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_demux_router

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of all ports.
REQ-002 Parameter DEPTH, default 2, is the entry count of each per-output buffer; legal values are powers of two, 2 or more.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  router accepts the word this cycle.
REQ-007 in_sel  input  1  destination: 0 selects port 0, 1 selects port 1.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 out0_valid / out1_valid  output  1  port holds a word.
REQ-010 out0_ready / out1_ready  input  1  downstream consumes the word.
REQ-011 out0_data / out1_data  output  WIDTH  head word of the port buffer.
REQ-012 cnt0 / cnt1  output  16  accepted-word counters; these ports exist only when DEMUX_COUNT_EN is defined.

Function
REQ-013 A transfer occurs on a clock edge where in_valid and in_ready are both high; in_data SHALL then be pushed into the buffer named by in_sel.
REQ-014 in_ready SHALL equal NOT full of the buffer selected by in_sel; it SHALL NOT depend on out*_ready, so there is no combinational ready path.
REQ-015 A pop occurs on a clock edge where outN_valid and outN_ready are both high; the head word SHALL be removed.
REQ-016 outN_valid SHALL be high exactly when buffer N is not empty; outN_data SHALL be the head word, driven from a register or a RAM read with no added latency.
REQ-017 Latency: a word accepted at edge k SHALL appear on the empty target port at edge k, and be visible the following cycle.
REQ-018 Order SHALL be preserved within each port; there is no ordering relationship between ports.
REQ-019 A push and a pop on the same non-full buffer in the same cycle SHALL leave the occupancy unchanged.
REQ-020 A full buffer SHALL refuse pushes even when it pops in the same cycle.
REQ-021 Traffic to one port SHALL be unaffected by backpressure on the other port; there is no head-of-line blocking beyond the current in_sel.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits wide.
REQ-023 outN_data SHALL hold its value while outN_valid is high and outN_ready is low.

Reset
REQ-024 When rst_n is low, all pointers and occupancy SHALL clear asynchronously, and out0_valid, out1_valid and in_ready-derived state SHALL be 0.
REQ-025 Buffered words SHALL be discarded on reset, including words reset mid-stream; the data storage itself need not be cleared.
REQ-026 While rst_n is low, in_ready SHALL be 1, following REQ-014 with empty buffers, but no push SHALL take effect.
REQ-027 cnt0 and cnt1 SHALL reset to 0.

Configuration
REQ-028 Macro DEMUX_COUNT_EN controls the counters.
REQ-029 When DEMUX_COUNT_EN is defined, cnt0 and cnt1 SHALL increment on each push to their port and wrap from 16'hFFFF to 16'h0000.
REQ-030 When DEMUX_COUNT_EN is not defined, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package demux_pkg SHALL hold the default WIDTH (16), the default DEPTH (2), the counter width (16), and the port-index constants PORT0=0 and PORT1=1.
REQ-032 The per-port buffer SHALL be sub-module demux_fifo (push/full, pop/empty, head data), instantiated twice.

Verification
REQ-033 Reset: hold rst_n=0 → out0_valid=0, out1_valid=0, in_ready=1, and cnt0=cnt1=0; then release.
REQ-034 Routing: push 16'h0000 with sel=0, then 16'hFFFE with sel=1, both outputs ready → out0_data=16'h0000 one cycle after its push, out1_data=16'hFFFE one cycle after its push, and cnt0=1, cnt1=1.
REQ-035 Backpressure and full: out0_ready=0, push 16'h0001, 16'h0002, 16'h0003 with sel=0 → the third push is refused (in_ready=0); a sel=1 word is still accepted; releasing out0_ready drains 0001 then 0002 in order.
REQ-036 Simultaneous push and pop: port 0 holds one word, push 16'hAAAA while popping in the same cycle → occupancy stays 1 and the next head is 16'hAAAA.
REQ-037 Mid-operation reset: assert rst_n=0 with both buffers full → valids drop immediately (asynchronously) and no stale word appears after release.
REQ-038 Counter wrap (DEMUX_COUNT_EN defined): 65536 pushes to port 1 → cnt1 returns to 16'h0000 while cnt0 is unchanged.
